// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;
    localparam int WIDTH_DEFAULT = 32;
    localparam int ITER_LAST     = WIDTH_DEFAULT - 1;
    localparam logic [WIDTH_DEFAULT-1:0] INT_MIN = 32'h8000_0000;
    localparam logic [WIDTH_DEFAULT-1:0] NEG_ONE = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RUN  = 3'd1,
        S_FIX  = 3'd2,
        S_EXC  = 3'd3,
        S_DONE = 3'd4
    } div_state_e;
endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring shift/subtract step on unsigned magnitudes.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    always_comb begin
        rem_sh = {rem_i, quo_i[WIDTH-1]};
        // rem < dvs <= 2^(WIDTH-1), so the MSB of the WIDTH+1 bit difference is the borrow
        trial  = rem_sh - {1'b0, dvs_i};
        if (!trial[WIDTH]) begin
            rem_o = trial[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = rem_sh[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/seq_divider.sv
// Multicycle signed divider: sign-magnitude conversion, WIDTH restoring steps,
// sign fix-up, one-cycle ready pulse. Divide-by-zero and INT_MIN/-1 short-circuit.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, a_q, a_d;
    logic             qneg_q, qneg_d, rneg_q, rneg_d;
    logic [WIDTH-1:0] result_q, result_d, remainder_q, remainder_d;
    logic             exc_q, exc_d;
    logic [WIDTH-1:0] rem_nx, quo_nx;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (rem_nx),
        .quo_o (quo_nx)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        a_d         = a_q;
        qneg_d      = qneg_q;
        rneg_d      = rneg_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        exc_d       = exc_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (ctrl_DIV) begin
                    a_d    = data_operandA;
                    rem_d  = '0;
                    quo_d  = mag(data_operandA);
                    dvs_d  = mag(data_operandB);
                    qneg_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    rneg_d = data_operandA[WIDTH-1];
                    cnt_d  = '0;
                    if (data_operandB == '0 ||
                        (data_operandA == WIDTH'(INT_MIN) && data_operandB == WIDTH'(NEG_ONE)))
                        state_d = S_EXC;
                    else
                        state_d = S_RUN;
                end
            end
            S_RUN: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                result_d    = qneg_q ? -quo_q : quo_q;
                remainder_d = rneg_q ? -rem_q : rem_q;
                exc_d       = 1'b0;
                state_d     = S_DONE;
            end
            S_EXC: begin
                // A zero divisor magnitude only arises from B == 0; otherwise this is INT_MIN / -1
                if (dvs_q == '0) begin
                    result_d    = '0;
                    remainder_d = a_q;
                end else begin
                    result_d    = WIDTH'(INT_MIN);
                    remainder_d = '0;
                end
                exc_d   = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            result_q    <= '0;
            remainder_q <= '0;
            exc_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            exc_q       <= exc_d;
        end
    end

    always_ff @(posedge clock) begin
        rem_q  <= rem_d;
        quo_q  <= quo_d;
        dvs_q  <= dvs_d;
        a_q    <= a_d;
        qneg_q <= qneg_d;
        rneg_q <= rneg_d;
    end

    assign data_result    = result_q;
    assign data_remainder = remainder_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == S_DONE);
    assign busy           = (state_q == S_RUN) || (state_q == S_FIX) || (state_q == S_EXC);
endmodule

// File: tb/tb_seq_divider.sv
// Directed table-driven bench for seq_divider plus multi-cycle corner sequences.
module tb_seq_divider;
    logic        clk = 1'b0;
    logic        rst;
    logic        div;
    logic [31:0] opa, opb;
    logic [31:0] res, rem;
    logic        exc, rdy, busy;

    int n_vec = 0;
    int n_mis = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        exc;
        int          lat;
    } vec_t;

    vec_t tbl[13];

    seq_divider dut (
        .clock          (clk),
        .reset          (rst),
        .ctrl_DIV       (div),
        .data_operandA  (opa),
        .data_operandB  (opb),
        .data_result    (res),
        .data_remainder (rem),
        .data_exception (exc),
        .data_resultRDY (rdy),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive a start so that the next rising edge is E0; returns #1 after E0.
    task automatic start(input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        opa = a; opb = b; div = 1'b1;
        @(posedge clk);
        #1 div = 1'b0;
    endtask

    // Counts edges until RDY is seen; busy must be high before and low in the RDY cycle.
    task automatic wait_rdy(output int lat, output logic busy_ok);
        lat = -1;
        busy_ok = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (rdy) begin
                lat = k;
                if (busy) busy_ok = 1'b0;
                break;
            end else if (!busy) begin
                busy_ok = 1'b0;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int   lat;
        logic bok;
        logic [31:0] q_seen;
        start(v.a, v.b);
        wait_rdy(lat, bok);
        chk({tag, "_lat"}, 32'(lat), 32'(v.lat));
        chk({tag, "_busy"}, {31'd0, bok}, 32'd1);
        chk({tag, "_q"}, res, v.q);
        chk({tag, "_r"}, rem, v.r);
        chk({tag, "_exc"}, {31'd0, exc}, {31'd0, v.exc});
        q_seen = res;
        @(posedge clk);
        #1;
        chk({tag, "_rdy_1cyc"}, {31'd0, rdy}, 32'd0);
        chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        chk({tag, "_q_hold"}, res, v.q);
    endtask

    initial begin
        int   lat;
        logic bok;
        logic seen;
        tbl[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
        tbl[1]  = '{32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 33};
        tbl[2]  = '{32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 33};
        tbl[3]  = '{32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 33};
        tbl[4]  = '{32'd5,          32'd0,          32'd0,          32'd5,          1'b1, 1};
        tbl[5]  = '{32'hFFFFFFFB,   32'd0,          32'd0,          32'hFFFFFFFB,   1'b1, 1};
        tbl[6]  = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b1, 1};
        tbl[7]  = '{32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0, 33};
        tbl[8]  = '{32'h80000000,   32'd7,          32'hEDB6DB6E,   32'hFFFFFFFE,   1'b0, 33};
        tbl[9]  = '{32'd7,          32'd100,        32'd0,          32'd7,          1'b0, 33};
        tbl[10] = '{32'h7FFFFFFF,   32'h80000000,   32'd0,          32'h7FFFFFFF,   1'b0, 33};
        tbl[11] = '{32'h80000000,   32'h80000000,   32'd1,          32'd0,          1'b0, 33};
        tbl[12] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33};

        rst = 1'b1; div = 1'b0; opa = '0; opb = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_q", res, 32'd0);
        chk("reset_r", rem, 32'd0);
        chk("reset_exc", {31'd0, exc}, 32'd0);
        chk("reset_rdy", {31'd0, rdy}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("v%0d", i));

        // Start request during RUN (at E10) must be ignored.
        start(32'd100, 32'd7);
        repeat (9) @(posedge clk);
        @(negedge clk);
        opa = 32'd999; opb = 32'd3; div = 1'b1;
        @(posedge clk);
        #1 div = 1'b0;
        wait_rdy(lat, bok);
        chk("ign_lat", 32'(lat), 32'd23);
        chk("ign_q", res, 32'd14);
        chk("ign_r", rem, 32'd2);

        // Back-to-back start issued in the RDY cycle.
        start(32'd100, 32'd7);
        wait_rdy(lat, bok);
        chk("b2b_first_q", res, 32'd14);
        opa = 32'hFFFFFF9C; opb = 32'd7; div = 1'b1;
        @(posedge clk);
        #1 div = 1'b0;
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_hold_q", res, 32'd14);
        wait_rdy(lat, bok);
        chk("b2b_lat", 32'(lat), 32'd33);
        chk("b2b_q", res, 32'hFFFFFFF2);
        chk("b2b_r", rem, 32'hFFFFFFFE);

        // Reset at E15 discards the operation.
        start(32'd100, 32'd7);
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_q", res, 32'd0);
        chk("mid_rst_r", rem, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (rdy) seen = 1'b1;
        end
        chk("mid_rst_no_rdy", {31'd0, seen}, 32'd0);
        run_vec(tbl[2], "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
